// File: rtl/wb_mux_n.sv
// wb_mux_n: registered 1-to-N Wishbone interconnect; decodes a peripheral index from an address
// field and answers unmapped (and, with WB_MUX_N_TIMEOUT_EN defined, hung) accesses with an error.
module wb_mux_n #(
   parameter int          NUM_PERIPH     = 4,
   parameter int          SEL_LSB        = 20,
   parameter int          SEL_BITS       = 2,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hBADC0DE5
) (
   input  logic                       io_wbs_clk,
   input  logic                       io_wbs_rst,
   input  logic [31:0]                io_wbs_adr,
   input  logic [31:0]                io_wbs_datwr,
   input  logic [3:0]                 io_wbs_sel,
   input  logic                       io_wbs_we,
   input  logic                       io_wbs_stb,
   input  logic                       io_wbs_cyc,
   output logic [31:0]                io_wbs_datrd,
   output logic                       io_wbs_ack,
   output logic                       err_o,
   output logic [NUM_PERIPH*32-1:0]   io_wbs_adr_p,
   output logic [NUM_PERIPH*32-1:0]   io_wbs_datwr_p,
   output logic [NUM_PERIPH*4-1:0]    io_wbs_sel_p,
   output logic [NUM_PERIPH-1:0]      io_wbs_we_p,
   output logic [NUM_PERIPH-1:0]      io_wbs_stb_p,
   output logic [NUM_PERIPH-1:0]      io_wbs_cyc_p,
   input  logic [NUM_PERIPH*32-1:0]   io_wbs_datrd_p,
   input  logic [NUM_PERIPH-1:0]      io_wbs_ack_p
);

   if (NUM_PERIPH < 1 || NUM_PERIPH > (1 << SEL_BITS)) begin : g_bad_num_periph
      $error("wb_mux_n: NUM_PERIPH must lie in 1..2**SEL_BITS");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_mux_n: TIMEOUT_CYCLES must lie in 1..65535");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                r_state;
   logic [31:0]           r_adr;
   logic [31:0]           r_datwr;
   logic [3:0]            r_sel;
   logic                  r_we;
   logic [SEL_BITS-1:0]   r_idx;
   logic [NUM_PERIPH-1:0] r_stb_p;
   logic                  r_ack;
   logic [31:0]           r_datrd;
   logic                  r_err;

   logic [SEL_BITS-1:0]   w_idx;
   logic [NUM_PERIPH-1:0] w_onehot;
   logic                  w_mapped;
   logic                  w_ack_sel;
   logic [31:0]           w_rd_sel;

`ifdef WB_MUX_N_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]           r_cnt;
`endif

   assign w_idx = io_wbs_adr[SEL_LSB +: SEL_BITS];

   // An index is mapped exactly when it selects one of the existing ports.
   always_comb begin
      w_onehot  = '0;
      w_ack_sel = 1'b0;
      w_rd_sel  = '0;
      for (int k = 0; k < NUM_PERIPH; k++) begin
         w_onehot[k] = (w_idx == SEL_BITS'(k));
         if (r_idx == SEL_BITS'(k)) begin
            w_ack_sel = io_wbs_ack_p[k];
            w_rd_sel  = io_wbs_datrd_p[32*k +: 32];
         end
      end
   end

   assign w_mapped = |w_onehot;

   always_ff @(posedge io_wbs_clk) begin
      if (io_wbs_rst) begin
         r_state <= S_IDLE;
         r_adr   <= '0;
         r_datwr <= '0;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_stb_p <= '0;
         r_ack   <= 1'b0;
         r_datrd <= '0;
         r_err   <= 1'b0;
`ifdef WB_MUX_N_TIMEOUT_EN
         r_cnt   <= '0;
`endif
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_wbs_cyc && io_wbs_stb) begin
                  r_adr   <= io_wbs_adr;
                  r_datwr <= io_wbs_datwr;
                  r_sel   <= io_wbs_sel;
                  r_we    <= io_wbs_we;
                  r_idx   <= w_idx;
                  if (w_mapped) begin
                     r_stb_p <= w_onehot;
                     r_state <= S_ACCESS;
`ifdef WB_MUX_N_TIMEOUT_EN
                     r_cnt   <= '0;
`endif
                  end else begin
                     r_datrd <= ERR_DATA;
                     r_err   <= 1'b1;
                     r_ack   <= 1'b1;
                     r_state <= S_RESP;
                  end
               end
            end
            S_ACCESS: begin
               // A master that has given up takes precedence over a late peripheral ack.
               if (!io_wbs_cyc) begin
                  r_stb_p <= '0;
                  r_state <= S_IDLE;
               end else if (w_ack_sel) begin
                  r_stb_p <= '0;
                  r_datrd <= w_rd_sel;
                  r_ack   <= 1'b1;
                  r_state <= S_RESP;
               end
`ifdef WB_MUX_N_TIMEOUT_EN
               else if (r_cnt == TO_LAST) begin
                  r_stb_p <= '0;
                  r_datrd <= ERR_DATA;
                  r_err   <= 1'b1;
                  r_ack   <= 1'b1;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
`endif
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io_wbs_ack     = r_ack;
   assign io_wbs_datrd   = r_ack ? r_datrd : 32'd0;
   assign err_o          = r_err;
   assign io_wbs_adr_p   = {NUM_PERIPH{r_adr}};
   assign io_wbs_datwr_p = {NUM_PERIPH{r_datwr}};
   assign io_wbs_sel_p   = {NUM_PERIPH{r_sel}};
   assign io_wbs_we_p    = {NUM_PERIPH{r_we}};
   assign io_wbs_stb_p   = r_stb_p;
   assign io_wbs_cyc_p   = r_stb_p;

endmodule
